// File: rtl/m65_pkg.sv
// Shared definitions for the 65xx-style bus master: bus state encoding and
// default parameter values.
package m65_pkg;

  // Bus sequencer states: IDLE between transfers, PH1/PH2 for the two phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2
  } bus_state_t;

  // Default parameter values.
  localparam int DEF_AW           = 16;
  localparam int DEF_DW           = 8;
  localparam int DEF_DIV          = 1;
  localparam int DEF_RDY_ON_WRITE = 0;
  localparam int DEF_TIMEOUT      = 1024;

  // Counter widths cover DIV up to 255 and TIMEOUT up to 65535.
  localparam int PH_CNT_W = 8;
  localparam int ST_CNT_W = 16;

endpackage

// File: rtl/m65_phase_timer.sv
// Phase and stretch timer for the bus master. The phase counter walks
// 0..DIV-1 within PH1 and PH2; the stretch counter counts PH2 cycles held
// by RDY and flags when the TIMEOUT limit has been reached.
module m65_phase_timer
  import m65_pkg::*;
#(
  parameter int DIV     = DEF_DIV,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic phase_clr,
  input  logic phase_inc,
  input  logic stretch_clr,
  input  logic stretch_inc,
  output logic last_cycle,
  output logic timeout
);

  localparam logic [PH_CNT_W-1:0] PH_LAST  = PH_CNT_W'(DIV - 1);
  localparam logic [ST_CNT_W-1:0] ST_LIMIT = ST_CNT_W'(TIMEOUT);

  logic [PH_CNT_W-1:0] ph_cnt_reg;
  logic [ST_CNT_W-1:0] st_cnt_reg;

  // Phase counter: cleared at every phase boundary, held while stretched.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_cnt_reg <= '0;
    end else if (phase_clr) begin
      ph_cnt_reg <= '0;
    end else if (phase_inc) begin
      ph_cnt_reg <= ph_cnt_reg + PH_CNT_W'(1);
    end
  end

  // Stretch counter: counts RDY-held cycles of the current transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_cnt_reg <= '0;
    end else if (stretch_clr) begin
      st_cnt_reg <= '0;
    end else if (stretch_inc) begin
      st_cnt_reg <= st_cnt_reg + ST_CNT_W'(1);
    end
  end

  assign last_cycle = (ph_cnt_reg == PH_LAST);
  assign timeout    = (st_cnt_reg == ST_LIMIT);

endmodule

// File: rtl/m65_bus_master.sv
// 65xx-style bus master: turns core request/response handshakes into
// two-phase (PH1/PH2) external bus cycles with RDY stretching, a stretch
// timeout, AEC bus release and back-to-back transfers.
module m65_bus_master
  import m65_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int DIV          = DEF_DIV,
  parameter int RDY_ON_WRITE = DEF_RDY_ON_WRITE,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic          req_sync,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          PH1OUT,
  output logic          PH2OUT,
  output logic [AW-1:0] A,
  output logic          A_oe,
  output logic [DW-1:0] D_out,
  output logic          D_oe,
  input  logic [DW-1:0] D_in,
  output logic          RWn,
  output logic          SYNC,
  input  logic          RDY,
  input  logic          AEC
);

  bus_state_t state_reg, state_next;

  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic          we_reg;
  logic          sync_reg;

  logic          rsp_valid_reg;
  logic          rsp_err_reg;
  logic [DW-1:0] rsp_rdata_reg;

  logic last_cycle;
  logic timeout;
  logic phase_clr;
  logic phase_inc;
  logic stretch_clr;
  logic stretch_inc;

  logic in_ph2_last;
  logic stretch_req;
  logic stretch_wait;
  logic complete;
  logic timeout_done;
  logic accept;

  m65_phase_timer #(
    .DIV     (DIV),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .phase_clr   (phase_clr),
    .phase_inc   (phase_inc),
    .stretch_clr (stretch_clr),
    .stretch_inc (stretch_inc),
    .last_cycle  (last_cycle),
    .timeout     (timeout)
  );

  // RDY only stretches reads unless write stretching is enabled.
  assign stretch_req  = !RDY && (!we_reg || (RDY_ON_WRITE != 0));
  assign in_ph2_last  = (state_reg == PH2) && last_cycle;
  assign stretch_wait = in_ph2_last && stretch_req && !timeout;
  // The transfer ends on the last PH2 cycle unless it is being held; if RDY
  // is still low at that point the stretch limit has been hit.
  assign complete     = in_ph2_last && !stretch_wait;
  assign timeout_done = complete && stretch_req;

  // Ready in IDLE (when the bus is ours) or on a completing edge, so a new
  // request can chain straight into PH1.
  assign req_ready = ((state_reg == IDLE) && AEC) || complete;
  assign accept    = req_valid && req_ready;

  // Bus state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and timer control.
  always_comb begin
    state_next  = state_reg;
    phase_clr   = 1'b0;
    phase_inc   = 1'b0;
    stretch_clr = 1'b0;
    stretch_inc = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next  = PH1;
          phase_clr   = 1'b1;
          stretch_clr = 1'b1;
        end
      end
      PH1: begin
        if (last_cycle) begin
          state_next = PH2;
          phase_clr  = 1'b1;
        end else begin
          phase_inc = 1'b1;
        end
      end
      PH2: begin
        if (!last_cycle) begin
          phase_inc = 1'b1;
        end else if (stretch_wait) begin
          stretch_inc = 1'b1;
        end else begin
          phase_clr   = 1'b1;
          stretch_clr = 1'b1;
          state_next  = accept ? PH1 : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the request fields when a transfer is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      sync_reg  <= 1'b0;
    end else if (accept) begin
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
      we_reg    <= req_we;
      sync_reg  <= req_sync;
    end
  end

  // Response: one-cycle pulse after completion with data sampled on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= complete;
      if (complete) begin
        rsp_err_reg <= timeout_done;
        if (timeout_done) begin
          rsp_rdata_reg <= '1;
        end else if (we_reg) begin
          rsp_rdata_reg <= '0;
        end else begin
          rsp_rdata_reg <= D_in;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

  // Pads: address/control held for the whole transfer; AEC gates the drivers
  // combinationally so a release takes effect in the same cycle. Data is
  // driven only in PH2, leaving PH1 as a turnaround gap.
  assign PH1OUT = (state_reg != PH2);
  assign PH2OUT = (state_reg == PH2);
  assign A      = addr_reg;
  assign A_oe   = (state_reg != IDLE) && AEC;
  assign D_out  = wdata_reg;
  assign D_oe   = (state_reg == PH2) && we_reg && AEC;
  assign RWn    = (state_reg == IDLE) || !we_reg;
  assign SYNC   = (state_reg != IDLE) && sync_reg;

endmodule

// File: tb/tb_m65_bus_master.sv
// Directed bench for m65_bus_master: a DIV=1 instance (default timeout) and a
// DIV=2 instance (TIMEOUT=4) share the same stimulus; each test targets one.
module tb_m65_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_we, req_sync, RDY, AEC;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, D_in;

  logic        req_ready_1, rsp_valid_1, rsp_err_1, PH1OUT_1, PH2OUT_1;
  logic        A_oe_1, D_oe_1, RWn_1, SYNC_1;
  logic [7:0]  rsp_rdata_1, D_out_1;
  logic [15:0] A_1;
  logic        req_ready_2, rsp_valid_2, rsp_err_2, PH1OUT_2, PH2OUT_2;
  logic        A_oe_2, D_oe_2, RWn_2, SYNC_2;
  logic [7:0]  rsp_rdata_2, D_out_2;
  logic [15:0] A_2;

  m65_bus_master #(.AW(16), .DW(8), .DIV(1), .RDY_ON_WRITE(0), .TIMEOUT(1024)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_1),
    .req_we(req_we), .req_sync(req_sync), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_1), .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1),
    .PH1OUT(PH1OUT_1), .PH2OUT(PH2OUT_1), .A(A_1), .A_oe(A_oe_1),
    .D_out(D_out_1), .D_oe(D_oe_1), .D_in(D_in), .RWn(RWn_1), .SYNC(SYNC_1),
    .RDY(RDY), .AEC(AEC));

  m65_bus_master #(.AW(16), .DW(8), .DIV(2), .RDY_ON_WRITE(0), .TIMEOUT(4)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_2),
    .req_we(req_we), .req_sync(req_sync), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_2), .rsp_rdata(rsp_rdata_2), .rsp_err(rsp_err_2),
    .PH1OUT(PH1OUT_2), .PH2OUT(PH2OUT_2), .A(A_2), .A_oe(A_oe_2),
    .D_out(D_out_2), .D_oe(D_oe_2), .D_in(D_in), .RWn(RWn_2), .SYNC(SYNC_2),
    .RDY(RDY), .AEC(AEC));

  // Per-cycle control snapshot: {rsp_valid, PH1OUT, PH2OUT, RWn, SYNC, A_oe, D_oe}
  logic [6:0]  ctl_1, ctl_2;
  // Full reset snapshot: {rsp_valid, rsp_err, rsp_rdata, A, A_oe, D_oe, RWn, SYNC, PH1OUT, PH2OUT}
  logic [31:0] o_1, o_2;
  assign ctl_1 = {rsp_valid_1, PH1OUT_1, PH2OUT_1, RWn_1, SYNC_1, A_oe_1, D_oe_1};
  assign ctl_2 = {rsp_valid_2, PH1OUT_2, PH2OUT_2, RWn_2, SYNC_2, A_oe_2, D_oe_2};
  assign o_1 = {rsp_valid_1, rsp_err_1, rsp_rdata_1, A_1, A_oe_1, D_oe_1, RWn_1, SYNC_1, PH1OUT_1, PH2OUT_1};
  assign o_2 = {rsp_valid_2, rsp_err_2, rsp_rdata_2, A_2, A_oe_2, D_oe_2, RWn_2, SYNC_2, PH1OUT_2, PH2OUT_2};

  localparam logic [31:0] RST_VEC  = 32'h0000_000A;
  localparam logic [6:0]  CTL_IDLE = 7'b0101000;
  localparam logic [6:0]  CTL_RSP  = 7'b1101000;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    RDY = 1'b1;
    AEC = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One transfer from IDLE on the selected instance. RDY is held low for
  // `low` cycles starting at the last PH2 cycle; lat counts falling edges
  // from the accept edge to the one where rsp_valid is seen.
  task automatic run_txn(input bit sel, input int div, input logic we, input logic sync,
                         input logic [15:0] addr, input logic [7:0] wdata, input logic [7:0] din,
                         input int low, input int lat, input logic [7:0] exp_rdata,
                         input logic exp_err, input string name);
    logic [6:0] ev;
    logic [7:0] rd;
    logic       er;
    @(negedge clk);
    req_we = we; req_sync = sync; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1; D_in = din; RDY = 1'b1;
    #1;
    chk({name, ".ready"}, 32'(sel ? req_ready_2 : req_ready_1), 32'd1);
    rd = 8'h00; er = 1'b0;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      if (n == lat)      ev = CTL_RSP;
      else if (n <= div) ev = {3'b010, ~we, sync, 1'b1, 1'b0};
      else               ev = {3'b001, ~we, sync, 1'b1, we};
      chk($sformatf("%s.ctl@%0d", name, n), 32'(sel ? ctl_2 : ctl_1), 32'(ev));
      if (n < lat)
        chk($sformatf("%s.addr@%0d", name, n), 32'(sel ? A_2 : A_1), 32'(addr));
      if (n < lat && n > div && we)
        chk($sformatf("%s.dout@%0d", name, n), 32'(sel ? D_out_2 : D_out_1), 32'(wdata));
      if (n == lat) begin
        rd = sel ? rsp_rdata_2 : rsp_rdata_1;
        er = sel ? rsp_err_2 : rsp_err_1;
        chk({name, ".rdata"}, 32'(rd), 32'(exp_rdata));
        chk({name, ".err"}, 32'(er), 32'(exp_err));
      end
      req_valid = 1'b0;
      RDY = !(n >= 2 * div && n < 2 * div + low);
    end
    RDY = 1'b1;
    $display("txn %s we=%0d addr=0x%04h rdata=0x%02h err=%0d lat=%0d", name, we, addr, rd, er, lat);
  endtask

  // Three back-to-back reads on the DIV=1 instance with req_valid held high;
  // optionally reset during PH2 of the second read.
  task automatic run_b2b(input bit do_rst);
    logic [15:0] ad [3];
    logic [7:0]  dn [3];
    logic [6:0]  ev;
    int nmax, i;
    ad[0] = 16'h0100; ad[1] = 16'h0101; ad[2] = 16'h0102;
    dn[0] = 8'h11;    dn[1] = 8'h22;    dn[2] = 8'h33;
    nmax = do_rst ? 4 : 7;
    @(negedge clk);
    req_we = 1'b0; req_sync = 1'b0; req_addr = ad[0]; req_valid = 1'b1;
    RDY = 1'b1; AEC = 1'b1; D_in = 8'hEE;
    for (int n = 1; n <= nmax; n++) begin
      @(negedge clk);
      i = (n - 1) / 2;
      if (n == 7)         ev = CTL_RSP;
      else if (n % 2 == 1) ev = {(n >= 3), 6'b101010};
      else                ev = 7'b0011010;
      chk($sformatf("b2b%0d.ctl@%0d", do_rst, n), 32'(ctl_1), 32'(ev));
      chk($sformatf("b2b%0d.ready@%0d", do_rst, n), 32'(req_ready_1),
          32'((n % 2 == 0) || (n == 7)));
      if (n < 7) chk($sformatf("b2b%0d.addr@%0d", do_rst, n), 32'(A_1), 32'(ad[i]));
      if (n % 2 == 1 && n >= 3)
        chk($sformatf("b2b%0d.rdata@%0d", do_rst, n), 32'(rsp_rdata_1), 32'(dn[(n - 3) / 2]));
      if (n % 2 == 1) begin
        if (i < 2) req_addr = ad[i + 1];
        D_in = 8'hEE;
      end else begin
        D_in = dn[i];
        if (n == 6) req_valid = 1'b0;
      end
      if (do_rst && n == 4) begin
        rst = 1'b1;
        req_valid = 1'b0;
      end
    end
    if (do_rst) begin
      @(negedge clk);
      chk("rst_abort.outputs", o_1, RST_VEC);
      rst = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk("rst_abort.no_rsp", 32'(ctl_1), 32'(CTL_IDLE));
      end
    end
    $display("txn b2b rst=%0d reads done", do_rst);
  endtask

  typedef struct {
    logic        we;
    logic        sync;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          low;
    int          lat;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // we sync addr      wdata  din    low lat exp_rdata
    vecs[0] = '{1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 0, 3, 8'hA5};
    vecs[1] = '{1'b0, 1'b1, 16'hFFFE, 8'h00, 8'h3C, 0, 3, 8'h3C};
    vecs[2] = '{1'b1, 1'b0, 16'h0200, 8'h77, 8'h99, 0, 3, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 16'h8000, 8'h00, 8'hC3, 5, 8, 8'hC3};
    vecs[4] = '{1'b1, 1'b0, 16'h8001, 8'h5A, 8'h11, 5, 3, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1, 4, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 16'hABCD, 8'h00, 8'hFF, 2, 5, 8'hFF};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_sync = 1'b0;
    req_addr = 16'h0; req_wdata = 8'h0; D_in = 8'h0; RDY = 1'b1; AEC = 1'b1;

    do_reset();
    chk("reset.dut1", o_1, RST_VEC);
    chk("reset.dut2", o_2, RST_VEC);
    chk("reset.ready", 32'(req_ready_1), 32'd1);

    for (int k = 0; k < 7; k++)
      run_txn(1'b0, 1, vecs[k].we, vecs[k].sync, vecs[k].addr, vecs[k].wdata, vecs[k].din,
              vecs[k].low, vecs[k].lat, vecs[k].exp_rdata, 1'b0, $sformatf("vec%0d", k));

    // AEC low in IDLE blocks acceptance; AEC dropped in PH2 of a write.
    do_reset();
    @(negedge clk);
    req_we = 1'b1; req_sync = 1'b0; req_addr = 16'h1111; req_wdata = 8'h22;
    req_valid = 1'b1; AEC = 1'b0;
    #1;
    chk("aec.idle_ready", 32'(req_ready_1), 32'd0);
    @(negedge clk);
    chk("aec.still_idle", 32'(ctl_1), 32'(CTL_IDLE));
    AEC = 1'b1;
    #1;
    chk("aec.ready_back", 32'(req_ready_1), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("aec.ph1", 32'(ctl_1), 32'(7'b0100010));
    @(negedge clk);
    chk("aec.ph2", 32'(ctl_1), 32'(7'b0010011));
    AEC = 1'b0;
    #1;
    chk("aec.drop", 32'(ctl_1), 32'(7'b0010000));
    @(negedge clk);
    chk("aec.rsp_on_time", 32'(ctl_1), 32'(CTL_RSP));
    chk("aec.rdata", 32'(rsp_rdata_1), 32'd0);
    AEC = 1'b1;
    $display("txn aec write addr=0x1111 done");

    do_reset();
    run_b2b(1'b0);
    do_reset();
    run_b2b(1'b1);

    // DIV=2 instance: write with RDY low (not stretched), read, then timeout.
    do_reset();
    run_txn(1'b1, 2, 1'b1, 1'b0, 16'hFFFC, 8'h5A, 8'h00, 3, 5, 8'h00, 1'b0, "d2_write");
    run_txn(1'b1, 2, 1'b0, 1'b1, 16'h2222, 8'h00, 8'h96, 0, 5, 8'h96, 1'b0, "d2_read");
    run_txn(1'b1, 2, 1'b0, 1'b0, 16'h4000, 8'h00, 8'h3C, 100, 9, 8'hFF, 1'b1, "d2_timeout");
    @(negedge clk);
    chk("d2_timeout.idle", 32'(ctl_2), 32'(CTL_IDLE));
    chk("d2_timeout.ready", 32'(req_ready_2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m65_bus_master.md
M65_BUS_MASTER -- requirements
Module: m65_bus_master

Interface
REQ-001 Parameter AW, default 16, external address width in bits.
REQ-002 Parameter DW, default 8, external data width in bits.
REQ-003 Parameter DIV, default 1, clk cycles per bus phase (PH1 or PH2); legal range 1..255.
REQ-004 Parameter RDY_ON_WRITE, default 0; when 1, RDY low also stretches write cycles (65C02 mode).
REQ-005 Parameter TIMEOUT, default 1024, maximum PH2 clk cycles spent stretched by RDY before a forced error completion; legal range 1..65535.
REQ-006 clk  in  1  sole clock; all logic is on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 req_valid / req_ready  in/out  1/1  core request handshake; transfer occurs when both are high on a clk edge.
REQ-009 req_we / req_sync  in  1/1  write request / opcode-fetch marker.
REQ-010 req_addr / req_wdata  in  AW/DW  request address / write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata / rsp_err  out  DW/1  read data / timeout flag, both valid with rsp_valid.
REQ-013 PH1OUT / PH2OUT  out  1/1  phase clocks, never high simultaneously.
REQ-014 A / A_oe  out  AW/1  address pads / address output enable.
REQ-015 D_out / D_oe / D_in  out/out/in  DW/1/DW  data pad out, data output enable, data pad in.
REQ-016 RWn / SYNC  out  1/1  1 = read, 0 = write / opcode-fetch strobe.
REQ-017 RDY / AEC  in  1/1  ready (low = stretch) / address enable control (low = release bus).

Function
REQ-018 States: IDLE, PH1, PH2; a phase counter counts 0..DIV-1 inside PH1 and PH2.
REQ-019 req_ready = 1 only in IDLE with AEC=1, or in the final PH2 cycle of a completing transfer (back-to-back).
REQ-020 On accept: latch addr, we, wdata, sync; next state PH1; counter = 0.
REQ-021 PH1: PH1OUT=1, PH2OUT=0; after DIV cycles go to PH2.
REQ-022 PH2: PH1OUT=0, PH2OUT=1; IDLE drives PH1OUT=1, PH2OUT=0.
REQ-023 A, RWn and SYNC hold the latched values for the whole of PH1 and PH2; SYNC=0 in IDLE.
REQ-024 D_oe = 1 only in PH2 of a write with AEC=1; D_oe is never 1 during PH1 (turnaround gap).
REQ-025 A_oe = AEC in PH1/PH2 and 0 in IDLE; AEC low mid-transfer releases the pads in the same cycle, and the transfer timing continues unchanged.
REQ-026 Stretch: if, in the last PH2 cycle, RDY=0 and (read or RDY_ON_WRITE=1), the counter holds and PH2 continues.
REQ-027 Completion happens in the last PH2 cycle when not stretched: rsp_rdata = D_in sampled on that edge (reads; 0 for writes), rsp_err = 0, and rsp_valid = 1 on the next cycle.
REQ-028 A stretch counter increments each stretched cycle; on reaching TIMEOUT the cycle completes with rsp_err=1 and rsp_rdata = all ones.
REQ-029 Back-to-back: when a request is accepted on the completion edge, the next state is PH1 directly, with no IDLE cycle.
REQ-030 DIV=1 yields a 2-clk bus cycle; the latency from accept to rsp_valid is 2*DIV + stretch + 1 clk.

Reset
REQ-031 rst forces IDLE, counters 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, A=0, A_oe=0, D_oe=0, RWn=1, SYNC=0, PH1OUT=1, PH2OUT=0.
REQ-032 rst mid-transfer aborts the transfer with no rsp_valid, and D_oe drops on the next edge.

Structure
REQ-033 The shared package m65_pkg holds the state enum (IDLE, PH1, PH2) and the default parameter constants.
REQ-034 One sub-module, m65_phase_timer, holds the phase counter and stretch/timeout counter and emits last_cycle and timeout.

Verification
REQ-035 DIV=1, read 0x1234, D_in=0xA5, RDY=1 -> rsp_valid 3 clk after accept, rsp_rdata=0xA5, rsp_err=0, RWn=1 throughout.
REQ-036 DIV=2, write 0xFFFC with data 0x5A -> D_oe=1 only in the 2 PH2 cycles, D_out=0x5A, RWn=0, PH1OUT/PH2OUT 2 clk each.
REQ-037 Read with RDY=0 for 5 PH2 cycles, RDY_ON_WRITE=0 -> latency +5; the same stimulus on a write -> no stretch.
REQ-038 TIMEOUT=4, RDY held 0 -> rsp_err=1, rsp_rdata=0xFF after 4 stretched cycles, then return to IDLE.
REQ-039 AEC=0 in IDLE -> req_ready=0; AEC dropped mid-write -> A_oe=D_oe=0 immediately, and rsp_valid still arrives on schedule.
REQ-040 Continuous req_valid, 3 reads -> no IDLE cycles between them; rst asserted in PH2 of the 2nd read -> no rsp for it, and all outputs take the reset values next cycle.
